byte_word_packer: RTL and testbench

Downstream consumer of the round-robin FIFO arbiter's byte stream. Packs up to four consecutive valid bytes into a 32-bit word with a byte-keep mask and buffers finished words in a small output queue behind a valid/ready handshake. The arbiter has no backpressure, so the packer absorbs one byte per cycle, reports lost words through a sticky overflow flag, and never stalls its input.

---
 rtl/byte_word_packer_pkg.sv | 21 ++
 rtl/byte_word_packer_if.sv | 25 ++
 rtl/byte_word_packer_queue.sv | 54 +++++
 rtl/byte_word_packer.sv | 86 ++++++++
 tb/tb_byte_word_packer.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/byte_word_packer_pkg.sv
// Shared widths, keep-mask type and queue entry layout for the byte-to-word packer.
package packer_pkg;
    localparam int BYTE_W = 8;
    localparam int LANES  = 4;
    localparam int WORD_W = 32;

    typedef logic [LANES-1:0]  keep_t;
    typedef logic [WORD_W-1:0] word_t;

    typedef struct packed {
        keep_t keep;
        word_t data;
    } entry_t;

    // Mask with the low cnt bits set; cnt runs 0..4 so a full word yields 4'b1111.
    function automatic keep_t lane_mask(input logic [2:0] cnt);
        logic [LANES:0] m;
        m = (5'b00001 << cnt) - 5'b00001;
        return m[LANES-1:0];
    endfunction
endpackage

// File: rtl/byte_word_packer_if.sv
// Byte-in / word-out signal bundle between the packer and its neighbours.
interface byte_word_packer_if #(parameter int DEPTH = 4);
    import packer_pkg::*;
    localparam int LW = $clog2(DEPTH) + 1;

    logic [BYTE_W-1:0] din;
    logic              din_valid;
    logic              flush;
    word_t             dout_data;
    keep_t             dout_keep;
    logic              dout_valid;
    logic              dout_ready;
    logic [LW-1:0]     level;
    logic              overflow;

    modport master (
        output din, din_valid, flush, dout_ready,
        input  dout_data, dout_keep, dout_valid, level, overflow
    );

    modport slave (
        input  din, din_valid, flush, dout_ready,
        output dout_data, dout_keep, dout_valid, level, overflow
    );
endinterface

// File: rtl/byte_word_packer_queue.sv
// DEPTH-entry word FIFO: synchronous write, combinational head read, owns pointer/level math.
module word_queue
    import packer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  entry_t                   push_entry,
    input  logic                     pop,
    output entry_t                   head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    entry_t          mem [DEPTH];
    logic [AW-1:0]   wptr;
    logic [AW-1:0]   rptr;
    logic            do_pop;

    assign empty  = (level == '0);
    assign full   = (level == (AW+1)'(DEPTH));
    assign head   = mem[rptr];
    assign do_pop = pop && !empty;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= push_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + AW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + AW'(1);
            end
            case ({push, do_pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end
endmodule

// File: rtl/byte_word_packer.sv
// Packs up to four bytes per word with a keep mask; input never stalls, words
// that find the queue full (and not draining) are dropped into a sticky overflow flag.
module byte_word_packer
    import packer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    byte_word_packer_if.slave      bus
);
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_FILL1 = 2'd1;
    localparam logic [1:0] ST_FILL2 = 2'd2;
    localparam logic [1:0] ST_FILL3 = 2'd3;

    logic [1:0]          idx;
    word_t               acc;
    word_t               merged;
    logic [2:0]          cnt;
    logic                done;
    logic                push;
    logic                pop;
    logic                drop;
    logic                overflow_q;
    entry_t              new_entry;
    entry_t              head;
    logic                q_full;
    logic                q_empty;
    logic [$clog2(DEPTH):0] q_level;

    // The incoming byte is merged before the flush decision so a same-cycle
    // byte+flush yields one word that includes that byte.
    always_comb begin
        merged = acc;
        if (bus.din_valid) begin
            merged[{idx, 3'b000} +: BYTE_W] = bus.din;
        end
        cnt  = {1'b0, idx} + {2'b00, bus.din_valid};
        done = (bus.din_valid && (idx == ST_FILL3)) || (bus.flush && (cnt != 3'd0));
    end

    assign pop            = !q_empty && bus.dout_ready;
    assign push           = done && (!q_full || pop);
    assign drop           = done && q_full && !pop;
    assign new_entry.data = merged;
    assign new_entry.keep = lane_mask(cnt);

    always_ff @(posedge clk) begin
        if (rst) begin
            idx        <= ST_EMPTY;
            acc        <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (done) begin
                idx <= ST_EMPTY;
                acc <= '0;
            end else if (bus.din_valid) begin
                idx <= idx + 2'd1;
                acc <= merged;
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    word_queue #(.DEPTH(DEPTH)) u_queue (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (new_entry),
        .pop        (pop),
        .head       (head),
        .full       (q_full),
        .empty      (q_empty),
        .level      (q_level)
    );

    // Head contents are forced to zero while the queue is empty.
    assign bus.dout_valid = !q_empty;
    assign bus.dout_data  = q_empty ? '0 : head.data;
    assign bus.dout_keep  = q_empty ? '0 : head.keep;
    assign bus.level      = q_level;
    assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_byte_word_packer.sv
// Directed bench for byte_word_packer with hand-computed expected words.
module tb_byte_word_packer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    byte_word_packer_if #(.DEPTH(4)) bus ();

    byte_word_packer #(.DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: inputs applied at the falling edge, outputs settle 1 unit after the rising edge.
    task automatic step(input logic [7:0] d, input logic v, input logic f, input logic r, input logic rs);
        @(negedge clk);
        bus.din        = d;
        bus.din_valid  = v;
        bus.flush      = f;
        bus.dout_ready = r;
        rst            = rs;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        bus.din        = 8'h00;
        bus.din_valid  = 1'b0;
        bus.flush      = 1'b0;
        bus.dout_ready = 1'b0;

        do_reset();
        check("rst_valid",    32'(bus.dout_valid), 32'd0);
        check("rst_data",     bus.dout_data,       32'h0);
        check("rst_keep",     32'(bus.dout_keep),  32'h0);
        check("rst_level",    32'(bus.level),      32'd0);
        check("rst_overflow", 32'(bus.overflow),   32'd0);

        // Four bytes straight through with the consumer ready.
        step(8'h11, 1'b1, 1'b0, 1'b1, 1'b0);
        step(8'h22, 1'b1, 1'b0, 1'b1, 1'b0);
        step(8'h33, 1'b1, 1'b0, 1'b1, 1'b0);
        check("full_novalid_early", 32'(bus.dout_valid), 32'd0);
        step(8'h44, 1'b1, 1'b0, 1'b1, 1'b0);
        check("full_valid", 32'(bus.dout_valid), 32'd1);
        check("full_data",  bus.dout_data,       32'h44332211);
        check("full_keep",  32'(bus.dout_keep),  32'hF);
        check("full_level", 32'(bus.level),      32'd1);
        step(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        check("full_popped_valid", 32'(bus.dout_valid), 32'd0);
        check("full_popped_level", 32'(bus.level),      32'd0);

        // Partial word closed by a lone flush; second flush while empty is a no-op.
        step(8'hAA, 1'b1, 1'b0, 1'b1, 1'b0);
        step(8'hBB, 1'b1, 1'b0, 1'b1, 1'b0);
        step(8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
        check("flush_valid", 32'(bus.dout_valid), 32'd1);
        check("flush_data",  bus.dout_data,       32'h0000BBAA);
        check("flush_keep",  32'(bus.dout_keep),  32'h3);
        step(8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
        check("flush_empty_valid", 32'(bus.dout_valid), 32'd0);
        check("flush_empty_level", 32'(bus.level),      32'd0);

        // Byte plus flush at idx=3 forms exactly one full word.
        step(8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
        step(8'h02, 1'b1, 1'b0, 1'b0, 1'b0);
        step(8'h03, 1'b1, 1'b0, 1'b0, 1'b0);
        step(8'h0D, 1'b1, 1'b1, 1'b0, 1'b0);
        check("merge_level", 32'(bus.level),     32'd1);
        check("merge_data",  bus.dout_data,      32'h0D030201);
        check("merge_keep",  32'(bus.dout_keep), 32'hF);
        step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        check("merge_no_extra", 32'(bus.level), 32'd1);
        step(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        check("merge_drained", 32'(bus.level), 32'd0);

        // Flush merged at idx=1 gives a two-byte word.
        step(8'hC1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(8'hC2, 1'b1, 1'b1, 1'b0, 1'b0);
        check("merge2_data", bus.dout_data,      32'h0000C2C1);
        check("merge2_keep", 32'(bus.dout_keep), 32'h3);

        // Overflow: (DEPTH+1) words with the consumer stalled.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(8'(8'h40 + i), 1'b1, 1'b0, 1'b0, 1'b0);
            if (i == 15) begin
                check("ovf_level_full", 32'(bus.level),    32'd4);
                check("ovf_not_yet",    32'(bus.overflow), 32'd0);
            end
        end
        check("ovf_set",        32'(bus.overflow),  32'd1);
        check("ovf_level",      32'(bus.level),     32'd4);
        check("ovf_head_data",  bus.dout_data,      32'h43424140);
        check("ovf_head_keep",  32'(bus.dout_keep), 32'hF);
        step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        check("ovf_sticky", 32'(bus.overflow), 32'd1);

        // Full queue draining while a word completes: push accepted.
        do_reset();
        check("ovf_cleared", 32'(bus.overflow), 32'd0);
        for (int i = 0; i < 16; i++) begin
            step(8'(8'h60 + i), 1'b1, 1'b0, 1'b0, 1'b0);
        end
        step(8'h70, 1'b1, 1'b0, 1'b0, 1'b0);
        step(8'h71, 1'b1, 1'b0, 1'b0, 1'b0);
        step(8'h72, 1'b1, 1'b0, 1'b0, 1'b0);
        check("pp_level_before", 32'(bus.level), 32'd4);
        step(8'h73, 1'b1, 1'b0, 1'b1, 1'b0);
        check("pp_level",    32'(bus.level),    32'd4);
        check("pp_overflow", 32'(bus.overflow), 32'd0);
        check("pp_new_head", bus.dout_data,     32'h67666564);

        // Reset mid-word with three words queued.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            step(8'(8'h80 + i), 1'b1, 1'b0, 1'b0, 1'b0);
        end
        step(8'h90, 1'b1, 1'b0, 1'b0, 1'b0);
        step(8'h91, 1'b1, 1'b0, 1'b0, 1'b0);
        step(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
        check("mid_level", 32'(bus.level), 32'd3);
        step(8'h92, 1'b1, 1'b0, 1'b0, 1'b1);
        check("mid_rst_valid",    32'(bus.dout_valid), 32'd0);
        check("mid_rst_level",    32'(bus.level),      32'd0);
        check("mid_rst_overflow", 32'(bus.overflow),   32'd0);
        check("mid_rst_data",     bus.dout_data,       32'h0);
        step(8'h51, 1'b1, 1'b0, 1'b0, 1'b0);
        step(8'h52, 1'b1, 1'b0, 1'b0, 1'b0);
        step(8'hEE, 1'b0, 1'b0, 1'b0, 1'b0);
        step(8'h53, 1'b1, 1'b0, 1'b0, 1'b0);
        check("clean_not_yet", 32'(bus.dout_valid), 32'd0);
        step(8'h54, 1'b1, 1'b0, 1'b0, 1'b0);
        check("clean_level", 32'(bus.level),     32'd1);
        check("clean_data",  bus.dout_data,      32'h54535251);
        check("clean_keep",  32'(bus.dout_keep), 32'hF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
